// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin synchronisers, ps2_clk glitch filter and a registered one-cycle pulse on each filtered falling edge.
// Fall pulse appears SYNC_STAGES+FILTER_LEN+1 cycles after a clean raw clock fall.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic wr_clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   filt;
    logic                   filt_q;
    logic [CNT_W-1:0]       cnt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Chains reset to 1 so an idle bus never looks like a fresh edge after reset.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // filt only follows clk_s after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            filt   <= 1'b1;
            filt_q <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
        end else begin
            filt_q <= filt;
            fall   <= filt_q & ~filt;
            if (clk_s != filt) begin
                if (cnt == CNT_LAST) begin
                    filt <= clk_s;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host deframer: one-cycle we/parity_err/frame_err strobes the cycle after the stop-bit fall.
// No backpressure: each accepted byte is presented once and wr_data holds it until the next good frame.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       wr_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] wr_data,
    output logic       we,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic                 fall;
    logic                 data_s;

    state_t               state, state_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_q, par_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
    logic [7:0]           wr_data_nxt;
    logic                 we_nxt, pe_nxt, fe_nxt;
    logic                 tmo_hit;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .wr_clk   (wr_clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_q;
        wr_data_nxt = wr_data;
        we_nxt      = 1'b0;
        pe_nxt      = 1'b0;
        fe_nxt      = 1'b0;

        // A stalled frame is abandoned even if an edge lands in the same cycle.
        if (tmo_hit) begin
            fe_nxt      = 1'b1;
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shreg_nxt[bit_cnt] = data_s;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt   = PARITY;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    par_nxt   = data_s;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!data_s) begin
                        fe_nxt = 1'b1;
                    end else if (odd_parity_ok(shreg, par_q)) begin
                        we_nxt      = 1'b1;
                        wr_data_nxt = shreg;
                    end else begin
                        pe_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if ((state == IDLE) || fall) begin
            tmo_nxt = '0;
        end else if (tmo_cnt == TMO_LAST) begin
            tmo_nxt = tmo_cnt;
        end else begin
            tmo_nxt = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            tmo_cnt    <= '0;
            wr_data    <= '0;
            we         <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            par_q      <= par_nxt;
            tmo_cnt    <= tmo_nxt;
            wr_data    <= wr_data_nxt;
            we         <= we_nxt;
            parity_err <= pe_nxt;
            frame_err  <= fe_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frame table plus glitch, reset-mid-frame and timeout sequences.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int SYNC = 2;
    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int LAT  = SYNC + FILT + 2;
    // Scaled PS/2 half period in wr_clk cycles so a whole run stays short.
    localparam int H    = 40;

    logic       wr_clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] wr_data;
    logic       we;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_rx #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .wr_data    (wr_data),
        .we         (we),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 wr_clk = ~wr_clk;

    int cyc = 0;
    always @(posedge wr_clk) cyc++;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int we_cyc = 0, fe_cyc = 0;
    int t_fall = 0;
    logic busy_seen = 1'b0;

    // Counts strobe-high cycles, so a stretched strobe shows up as a count of 2.
    always @(negedge wr_clk) begin
        if (we === 1'b1) begin
            we_cnt++;
            we_cyc = cyc;
        end
        if (parity_err === 1'b1) pe_cnt++;
        if (frame_err === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                               input logic bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Drives the first nbits of a frame; data changes mid-high, t_fall marks the last raw fall.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge wr_clk);
            ps2_data = frame[i];
            repeat (H / 2) @(negedge wr_clk);
            ps2_clk = 1'b0;
            t_fall  = cyc;
            repeat (H) @(negedge wr_clk);
            ps2_clk = 1'b1;
            repeat (H / 2 - 1) @(negedge wr_clk);
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_we;
        logic       exp_pe;
        logic       exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int w0, p0, f0;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        vecs[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge wr_clk);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge wr_clk);

        for (int v = 0; v < 9; v++) begin
            w0 = we_cnt; p0 = pe_cnt; f0 = fe_cnt;
            send_bits(make_frame(vecs[v].dat, vecs[v].bad_par, vecs[v].bad_stop), FRAME_BITS);
            check($sformatf("v%0d_we", v), 32'(we_cnt - w0), 32'(vecs[v].exp_we));
            check($sformatf("v%0d_parity_err", v), 32'(pe_cnt - p0), 32'(vecs[v].exp_pe));
            check($sformatf("v%0d_frame_err", v), 32'(fe_cnt - f0), 32'(vecs[v].exp_fe));
            check($sformatf("v%0d_wr_data", v), 32'(wr_data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
            if (vecs[v].exp_we)
                check($sformatf("v%0d_latency", v), 32'(we_cyc - t_fall), 32'(LAT));
        end

        // Short clock glitches with data low must not start a frame, including FILTER_LEN-1 cycles.
        busy_seen = 1'b0;
        @(negedge wr_clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge wr_clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge wr_clk);
        check("glitch3_busy", 32'(busy_seen), 32'h0);
        ps2_clk = 1'b0;
        repeat (FILT - 1) @(negedge wr_clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge wr_clk);
        check("glitch7_busy", 32'(busy_seen), 32'h0);
        ps2_data = 1'b1;
        repeat (10) @(negedge wr_clk);

        // Reset during DATA: back to IDLE on the next edge, no strobes.
        w0 = we_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_bits(make_frame(8'h29, 1'b0, 1'b0), 4);
        check("mid_busy_before_reset", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge wr_clk);
        check("mid_busy_after_reset", 32'(busy), 32'h0);
        reset    = 1'b0;
        ps2_data = 1'b1;
        repeat (50) @(negedge wr_clk);
        check("mid_reset_strobes", 32'((we_cnt - w0) + (pe_cnt - p0) + (fe_cnt - f0)), 32'h0);
        check("mid_reset_wr_data", 32'(wr_data), 32'h0);

        // Clock stops after 4 data bits: frame_err lands TMO cycles after a stop strobe would have.
        w0 = we_cnt; f0 = fe_cnt;
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 5);
        check("tmo_busy_stalled", 32'(busy), 32'h1);
        ps2_data = 1'b1;
        repeat (1100) @(negedge wr_clk);
        check("tmo_frame_err", 32'(fe_cnt - f0), 32'h1);
        check("tmo_we", 32'(we_cnt - w0), 32'h0);
        check("tmo_time", 32'(fe_cyc - t_fall), 32'(LAT + TMO));
        check("tmo_busy", 32'(busy), 32'h0);

        w0 = we_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_bits(make_frame(8'h29, 1'b0, 1'b0), FRAME_BITS);
        check("post_tmo_we", 32'(we_cnt - w0), 32'h1);
        check("post_tmo_errs", 32'((pe_cnt - p0) + (fe_cnt - f0)), 32'h0);
        check("post_tmo_wr_data", 32'(wr_data), 32'h29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
